// File: rtl/z_core_mdu.sv
// z_core_mdu: multi-cycle RV32M-style multiply/divide unit, generic in XLEN.
// Radix-2 shift-add multiply and restoring divide on magnitudes. Sign correction
// is applied when the result is loaded into mdu_out.
// Optional macro Z_CORE_MDU_FAST_MUL_EN: multiplies use a combinational
// XLEN x XLEN multiplier at accept instead of the iterative path.
module z_core_mdu #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            mdu_valid,
   output logic            mdu_ready,
   input  logic [2:0]      mdu_op,
   input  logic [XLEN-1:0] mdu_in1,
   input  logic [XLEN-1:0] mdu_in2,
   input  logic            mdu_flush,
   output logic [XLEN-1:0] mdu_out,
   output logic            mdu_done
);

   localparam int unsigned     CntW    = $clog2(XLEN + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(XLEN);
   localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

   state_t            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [2:0]        op_q;
   logic              fast_q;
   logic              neg_q;
   logic [XLEN-1:0]   a_q;
   logic [2*XLEN-1:0] prod_q;
   logic [XLEN-1:0]   out_q;
   logic              done_q;

   logic              accept;
   logic              is_div;
   logic              in1_sgn;
   logic              in2_sgn;
   logic              acc_neg;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   mag1;
   logic [XLEN-1:0]   mag2;
   logic [XLEN-1:0]   fast_res;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic [XLEN-1:0]   div_sub;
   logic              div_ge;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] iter_next;
   logic [2*XLEN-1:0] prod_sc;
   logic [XLEN-1:0]   div_sel;
   logic [XLEN-1:0]   final_res;

   assign mdu_ready = (state_q == StIdle);
   assign mdu_out   = out_q;
   assign mdu_done  = done_q;
   assign accept    = mdu_valid & (state_q == StIdle) & ~mdu_flush;

   // Decode operand signedness, magnitudes and the divide special cases at accept
   always_comb begin
      is_div   = mdu_op[2];
      // ops 3/5/7 (MULHU, DIVU, REMU) are fully unsigned; MULHSU has unsigned in2
      in1_sgn  = mdu_in1[XLEN-1] & ~(mdu_op[0] & (mdu_op[1] | mdu_op[2]));
      in2_sgn  = mdu_in2[XLEN-1] & ~(mdu_op[0] & (mdu_op[1] | mdu_op[2]))
                 & (mdu_op != 3'd2);
      mag1     = in1_sgn ? -mdu_in1 : mdu_in1;
      mag2     = in2_sgn ? -mdu_in2 : mdu_in2;
      // remainder takes the dividend's sign, everything else the XOR of signs
      acc_neg  = (is_div & mdu_op[1]) ? in1_sgn : (in1_sgn ^ in2_sgn);
      div_zero = is_div & (mdu_in2 == '0);
      div_ovf  = is_div & ~mdu_op[0] & (mdu_in1 == MinNeg) & (mdu_in2 == '1);
      if (div_zero) begin
         fast_res = mdu_op[1] ? mdu_in1 : '1;
      end else begin
         fast_res = mdu_op[1] ? '0 : mdu_in1;
      end
   end

`ifdef Z_CORE_MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] fmul_prod;
   assign fmul_prod = mag1 * mag2;
`endif

   // One shift-add or restoring-divide step, plus final sign correction
   always_comb begin
      mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
      mul_next  = prod_q[0] ? {mul_sum, prod_q[XLEN-1:1]} : {1'b0, prod_q[2*XLEN-1:1]};
      // upper half holds the partial remainder, lower half the dividend/quotient
      div_shift = prod_q[2*XLEN-1:XLEN-1];
      div_ge    = (div_shift >= {1'b0, a_q});
      div_sub   = div_shift[XLEN-1:0] - a_q;
      div_next  = div_ge ? {div_sub, prod_q[XLEN-2:0], 1'b1}
                         : {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
      iter_next = op_q[2] ? div_next : mul_next;

      prod_sc   = neg_q ? -prod_q : prod_q;
      div_sel   = op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
      if (fast_q) begin
         final_res = prod_q[XLEN-1:0];
      end else if (op_q[2]) begin
         final_res = neg_q ? -div_sel : div_sel;
      end else if (op_q[1:0] == 2'd0) begin
         final_res = prod_sc[XLEN-1:0];
      end else begin
         final_res = prod_sc[2*XLEN-1:XLEN];
      end
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         fast_q  <= 1'b0;
         neg_q   <= 1'b0;
         a_q     <= '0;
         prod_q  <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (accept) begin
                  op_q    <= mdu_op;
                  neg_q   <= acc_neg;
                  state_q <= StCalc;
                  // Results known at accept skip the iterations: the counter is
                  // preset so the next CALC cycle only loads the output.
                  if (div_zero | div_ovf) begin
                     fast_q <= 1'b1;
                     cnt_q  <= LastCnt;
                     a_q    <= '0;
                     prod_q <= {{XLEN{1'b0}}, fast_res};
                  end else if (is_div) begin
                     fast_q <= 1'b0;
                     cnt_q  <= '0;
                     a_q    <= mag2;
                     prod_q <= {{XLEN{1'b0}}, mag1};
                  end else begin
                     fast_q <= 1'b0;
`ifdef Z_CORE_MDU_FAST_MUL_EN
                     cnt_q  <= LastCnt;
                     a_q    <= mag1;
                     prod_q <= fmul_prod;
`else
                     cnt_q  <= '0;
                     a_q    <= mag1;
                     prod_q <= {{XLEN{1'b0}}, mag2};
`endif
                  end
               end
            end
            StCalc: begin
               if (mdu_flush) begin
                  state_q <= StIdle;
               end else if (cnt_q == LastCnt) begin
                  out_q   <= final_res;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  prod_q <= iter_next;
                  cnt_q  <= cnt_q + CntW'(1);
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_z_core_mdu.sv
// tb_z_core_mdu: directed self-checking bench for z_core_mdu at XLEN=32.
// Honours Z_CORE_MDU_FAST_MUL_EN for the expected multiply latency.
module tb_z_core_mdu;

   logic        clk = 1'b0;
   logic        rstn;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [2:0]  mdu_op;
   logic [31:0] mdu_in1;
   logic [31:0] mdu_in2;
   logic        mdu_flush;
   logic [31:0] mdu_out;
   logic        mdu_done;

   int n_cmp = 0;
   int n_err = 0;

   localparam int DivLat  = 33;
   localparam int FastLat = 1;
`ifdef Z_CORE_MDU_FAST_MUL_EN
   localparam int MulLat  = 1;
`else
   localparam int MulLat  = 33;
`endif

   z_core_mdu #(.XLEN(32)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .mdu_valid (mdu_valid),
      .mdu_ready (mdu_ready),
      .mdu_op    (mdu_op),
      .mdu_in1   (mdu_in1),
      .mdu_in2   (mdu_in2),
      .mdu_flush (mdu_flush),
      .mdu_out   (mdu_out),
      .mdu_done  (mdu_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, scramble inputs after accept, and measure edges to done.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
      int          edges;
      logic [31:0] res;
      logic        rdy_seen;
      @(negedge clk);
      check({tag, "_ready_before"}, {31'd0, mdu_ready}, 32'd1);
      mdu_op    = op;
      mdu_in1   = a;
      mdu_in2   = b;
      mdu_valid = 1'b1;
      @(posedge clk);
      #1;
      mdu_valid = 1'b0;
      mdu_in1   = ~a;
      mdu_in2   = 32'h5;
      mdu_op    = ~op;
      rdy_seen  = mdu_ready;
      res       = 32'hxxxx_xxxx;
      edges     = 0;
      while (edges < 100) begin
         @(posedge clk);
         edges++;
         #1;
         rdy_seen = rdy_seen | mdu_ready;
         if (mdu_done) begin
            res = mdu_out;
            break;
         end
      end
      check({tag, "_result"}, res, exp);
      check({tag, "_latency"}, edges, lat);
      check({tag, "_ready_busy"}, {31'd0, rdy_seen}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_ready_after"}, {31'd0, mdu_ready}, 32'd1);
      check({tag, "_done_width"}, {31'd0, mdu_done}, 32'd0);
   endtask

   initial begin
      int   done_cnt;

      rstn      = 1'b0;
      mdu_valid = 1'b0;
      mdu_flush = 1'b0;
      mdu_op    = 3'd0;
      mdu_in1   = 32'd0;
      mdu_in2   = 32'd0;
      #1;
      check("rst_ready", {31'd0, mdu_ready}, 32'd1);
      check("rst_out", mdu_out, 32'd0);
      check("rst_done", {31'd0, mdu_done}, 32'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // Multiplies
      do_op("mul",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat);
      do_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat);
      do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat);
      do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat);

      // Divides, including a negative divisor
      do_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, DivLat);
      do_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, DivLat);
      do_op("div_nd", 3'd4, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, DivLat);
      do_op("rem_nd", 3'd6, 32'd7,        32'hFFFF_FFFE, 32'd1,        DivLat);
      do_op("divu",   3'd5, 32'd100,      32'd7,        32'd14,       DivLat);
      do_op("remu",   3'd7, 32'd100,      32'd7,        32'd2,        DivLat);

      // Fast-path special cases
      do_op("divu_z", 3'd5, 32'h1234,     32'd0,        32'hFFFF_FFFF, FastLat);
      do_op("rem_z",  3'd6, 32'h1234,     32'd0,        32'h1234,     FastLat);
      do_op("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FastLat);
      do_op("rem_ov", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        FastLat);

      // Large unsigned operands
      do_op("divu_l", 3'd5, 32'hFFFF_FFFF, 32'h10,      32'h0FFF_FFFF, DivLat);
      do_op("remu_l", 3'd7, 32'hFFFF_FFFF, 32'h10,      32'hF,        DivLat);

      // Flush 10 cycles into a DIV
      @(negedge clk);
      mdu_op    = 3'd4;
      mdu_in1   = 32'd1000;
      mdu_in2   = 32'd3;
      mdu_valid = 1'b1;
      @(posedge clk);
      #1;
      mdu_valid = 1'b0;
      done_cnt  = 0;
      repeat (9) begin
         @(posedge clk);
         #1;
         if (mdu_done) done_cnt++;
      end
      @(negedge clk);
      mdu_flush = 1'b1;
      @(posedge clk);
      #1;
      if (mdu_done) done_cnt++;
      check("flush_ready", {31'd0, mdu_ready}, 32'd1);
      check("flush_out_held", mdu_out, 32'hF);
      @(negedge clk);
      mdu_flush = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (mdu_done) done_cnt++;
      end
      check("flush_no_done", done_cnt, 0);
      check("flush_out_after", mdu_out, 32'hF);

      do_op("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, MulLat);

      // Asynchronous reset in the middle of a MUL
      @(negedge clk);
      mdu_op    = 3'd0;
      mdu_in1   = 32'd5;
      mdu_in2   = 32'd6;
      mdu_valid = 1'b1;
      @(posedge clk);
      #1;
      mdu_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("arst_out", mdu_out, 32'd0);
      check("arst_done", {31'd0, mdu_done}, 32'd0);
      check("arst_ready", {31'd0, mdu_ready}, 32'd1);
      @(negedge clk);
      rstn     = 1'b1;
      done_cnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (mdu_done) done_cnt++;
      end
      check("arst_no_done", done_cnt, 0);
      check("arst_ready_after", {31'd0, mdu_ready}, 32'd1);

      // Flush in IDLE beats a simultaneous request
      @(negedge clk);
      mdu_op    = 3'd0;
      mdu_in1   = 32'd9;
      mdu_in2   = 32'd9;
      mdu_valid = 1'b1;
      mdu_flush = 1'b1;
      @(posedge clk);
      #1;
      check("idle_flush_ready", {31'd0, mdu_ready}, 32'd1);
      @(negedge clk);
      mdu_valid = 1'b0;
      mdu_flush = 1'b0;
      done_cnt  = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (mdu_done) done_cnt++;
      end
      check("idle_flush_no_done", done_cnt, 0);

      // First scenario again; latency follows the fast-multiply build option
      do_op("mul_rep", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MulLat);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
